// File: rtl/prng_pkg.sv
// Shared types and helpers for the prng_sched block.
// LFSR tap positions, reset seed, FSM state encoding and the step function.
package prng_pkg;

  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam int TAP_A = 5;
  localparam int TAP_B = 12;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    READY = 2'd1,
    ADV   = 2'd2
  } state_e;

  // One shift: the new bit enters at the top (s[15] is newest).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[TAP_A] ^ s[TAP_B], s[15:1]};
  endfunction

endpackage

// File: rtl/prng_sched_if.sv
// Requester-side bus of prng_sched: seeding, requests, grants and status.
// master = requesters/seeding logic, slave = the scheduler.
interface prng_sched_if #(
  parameter int NREQ = 4
);

  logic            seed_we;
  logic [15:0]     seed_val;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [15:0]     rnd;
  logic            rnd_vld;
  logic            busy;
  logic            lockup;

  modport master (
    output seed_we, seed_val, req,
    input  gnt, rnd, rnd_vld, busy, lockup
  );

  modport slave (
    input  seed_we, seed_val, req,
    output gnt, rnd, rnd_vld, busy, lockup
  );

endinterface

// File: rtl/prng_rr_arb.sv
// Combinational round-robin picker: first set request bit searching
// upward from ptr_i+1 with wrap-around. Outputs are zero when req_i==0.
module prng_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   index_o
);

  logic found;
  int   j;

  // Scan NREQ positions starting just past the last winner.
  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr_i) + i) % NREQ;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        index_o     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/prng_sched.sv
// Shared 16-bit LFSR word source with round-robin grant scheduling.
// Optional build macro: PRNG_LOCKUP_RECOVER_EN (all-zero state recovery).
module prng_sched #(
  parameter int          NREQ     = 4,
  parameter int          STEPS    = 1,
  parameter int          WARMUP   = 16,
  parameter logic [15:0] SEED_DEF = prng_pkg::SEED_DEF
) (
  input  logic         clk,
  input  logic         rst,
  prng_sched_if.slave  bus
);

  import prng_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam logic [7:0] CNT_WARM = 8'(WARMUP - 1);
  localparam logic [7:0] CNT_STEP = 8'(STEPS - 1);
  localparam state_e ST_SEED = (WARMUP == 0) ? READY : WARM;

  state_e          state_q, state_d;
  logic [15:0]     s_q, s_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [15:0]     rnd_q, rnd_d;
  logic            lock_q, lock_d;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            fix;

  prng_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i    (bus.req),
    .ptr_i    (rr_q),
    .onehot_o (win_oh),
    .index_o  (win_idx)
  );

`ifdef PRNG_LOCKUP_RECOVER_EN
  assign fix = (s_q == 16'h0000);
`else
  assign fix = 1'b0;
`endif

  // Next state: seeding wins, then shifting/grant by FSM state,
  // then zero-state recovery overrides the shift result.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    lock_d  = lock_q;
    if (bus.seed_we) begin
      s_d     = (bus.seed_val == 16'h0000) ? SEED_DEF : bus.seed_val;
      cnt_d   = CNT_WARM;
      state_d = ST_SEED;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        WARM, ADV: begin
          s_d = lfsr_step(s_q);
          if (cnt_q == 8'd0) state_d = READY;
          else cnt_d = cnt_q - 8'd1;
        end
        READY: begin
          if (|bus.req) begin
            gnt_d   = win_oh;
            rnd_d   = s_q;
            rr_d    = win_idx;
            cnt_d   = CNT_STEP;
            state_d = ADV;
          end
        end
        default: state_d = ST_SEED;
      endcase
      if (fix) begin
        s_d    = SEED_DEF;
        lock_d = 1'b1;
      end
    end
  end

  // State, LFSR, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SEED;
      s_q     <= SEED_DEF;
      cnt_q   <= CNT_WARM;
      rr_q    <= IW'(NREQ - 1);
      gnt_q   <= '0;
      rnd_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      lock_q  <= lock_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rnd     = rnd_q;
  assign bus.rnd_vld = |gnt_q;
  assign bus.busy    = (state_q != READY);
  assign bus.lockup  = lock_q;

endmodule

// File: tb/tb_prng_sched.sv
// Randomized scoreboard bench for prng_sched.
// Driver feeds a spec-level model; a monitor pops expectations per edge.
module tb_prng_sched;

  localparam int NREQ = 4;
  localparam int STEPS = 1;
  localparam int WARMUP = 16;
  localparam logic [15:0] SD = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prng_sched_if #(.NREQ(NREQ)) bus();

  prng_sched #(
    .NREQ     (NREQ),
    .STEPS    (STEPS),
    .WARMUP   (WARMUP),
    .SEED_DEF (SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [15:0]     w;
  } gexp_t;

  typedef struct packed {
    logic b;
    logic l;
    logic v;
  } cexp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  gexp_t mg;
  cexp_t mc;

  int total = 0;
  int bad = 0;

  // Model: remaining busy edges, word register, last winner, flag.
  int          m_busy;
  logic [15:0] m_s;
  int          m_ptr;
  bit          m_lock;
  bit          m_gr;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] s);
    int fb;
    fb = ((int'(s) >> 5) & 1) ^ ((int'(s) >> 12) & 1);
    return 16'((int'(s) >> 1) + (fb * 32768));
  endfunction

  task automatic model_reset();
    m_busy = WARMUP;
    m_s    = SD;
    m_ptr  = NREQ - 1;
    m_lock = 0;
    m_gr   = 0;
    gq.delete();
    cq.delete();
  endtask

  // What the coming clock edge should do, from the behavioural rules.
  task automatic model(input logic [NREQ-1:0] r, input logic we,
                       input logic [15:0] sv);
    logic [15:0] old;
    bit fix;
    int w;
    cexp_t c;
    gexp_t g;
    old  = m_s;
    m_gr = 0;
    fix  = 0;
    if (we) begin
      m_s    = (sv == 16'h0) ? SD : sv;
      m_busy = WARMUP;
      m_lock = 0;
    end else begin
`ifdef PRNG_LOCKUP_RECOVER_EN
      fix = (old == 16'h0);
`endif
      if (m_busy > 0) begin
        m_busy--;
        m_s = fix ? SD : nxt(old);
      end else begin
        if (fix) m_s = SD;
        if (r != 0) begin
          w = -1;
          for (int k = 1; k <= NREQ; k++) begin
            if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
          end
          g.g = '0;
          g.g[w] = 1'b1;
          g.w = old;
          gq.push_back(g);
          m_ptr  = w;
          m_busy = STEPS;
          m_gr   = 1;
        end
      end
      if (fix) m_lock = 1;
    end
    c.b = (m_busy > 0);
    c.l = m_lock;
    c.v = m_gr;
    cq.push_back(c);
  endtask

  // Drive inputs at a falling edge, model the next rising edge.
  task automatic cyc(input logic [NREQ-1:0] r, input logic we,
                     input logic [15:0] sv);
    bus.req      = r;
    bus.seed_we  = we;
    bus.seed_val = sv;
    model(r, we, sv);
    @(negedge clk);
  endtask

  // Hold req until the model says it is granted; bounded.
  task automatic until_grant(input logic [NREQ-1:0] r, input string n);
    int k;
    k = 0;
    m_gr = 0;
    while (!m_gr && k < 60) begin
      cyc(r, 1'b0, 16'h0);
      k++;
    end
    chk({n, "_grant_in_time"}, 32'(m_gr), 32'd1);
  endtask

  // Requesters: drop the cycle after own gnt, otherwise random raise/withdraw.
  task automatic rand_run(input int n, input bit seeds);
    logic [NREQ-1:0] r;
    r = '0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.gnt[i]) r[i] = 1'b0;
        else if (r[i]) r[i] = ($urandom_range(0, 49) != 0);
        else r[i] = ($urandom_range(0, 2) == 0);
      end
      if (seeds && $urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 3) == 0) cyc(r, 1'b1, 16'h0);
        else cyc(r, 1'b1, 16'($urandom));
      end else begin
        cyc(r, 1'b0, 16'h0);
      end
    end
  endtask

  // Monitor: one expectation record per edge, grant record when valid.
  always begin
    @(posedge clk);
    #1;
    if (!rst && cq.size() > 0) begin
      mc = cq.pop_front();
      chk("busy", 32'(bus.busy), 32'(mc.b));
      chk("lockup", 32'(bus.lockup), 32'(mc.l));
      chk("rnd_vld", 32'(bus.rnd_vld), 32'(mc.v));
      if (bus.rnd_vld) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(bus.gnt), 32'd0);
        end else begin
          mg = gq.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(mg.g));
          chk("rnd", 32'(bus.rnd), 32'(mg.w));
        end
      end
    end
  end

  initial begin
    bus.req      = '0;
    bus.seed_we  = 1'b0;
    bus.seed_val = 16'h0;
    model_reset();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rnd", 32'(bus.rnd), 32'd0);
    chk("rst_vld", 32'(bus.rnd_vld), 32'd0);
    chk("rst_lockup", 32'(bus.lockup), 32'd0);
    rst = 1'b0;

    // Warm-up then a single requester.
    for (int i = 0; i < 20; i++) cyc('0, 1'b0, 16'h0);
    until_grant(4'b0001, "t1");
    cyc('0, 1'b0, 16'h0);

    // All requesters, dropping for one cycle after own grant.
    for (int i = 0; i < 12; i++) begin
      logic [NREQ-1:0] r;
      r = 4'b1111 & ~bus.gnt;
      cyc(r, 1'b0, 16'h0);
    end

    rand_run(400, 1'b1);

    // Zero seed reloads the default and repeats the warm-up.
    cyc('0, 1'b1, 16'h0000);
    for (int i = 0; i < 20; i++) cyc('0, 1'b0, 16'h0);
    until_grant(4'b0001, "t3");
    cyc('0, 1'b0, 16'h0);

    // Seed load collides with a request in READY.
    for (int i = 0; i < 4; i++) cyc('0, 1'b0, 16'h0);
    chk("t5_ready", 32'(bus.busy), 32'd0);
    cyc(4'b0010, 1'b1, 16'h5A5A);
    chk("t5_no_gnt", 32'(bus.gnt), 32'd0);
    until_grant(4'b0010, "t5");
    cyc('0, 1'b0, 16'h0);

    // Seed that collapses to the all-zero state.
    cyc('0, 1'b1, 16'h0001);
    rand_run(80, 1'b0);

    // Reset while in ADV with a grant showing.
    until_grant(4'b1111, "t6a");
    rst = 1'b1;
    #1;
    chk("t6_gnt", 32'(bus.gnt), 32'd0);
    chk("t6_rnd", 32'(bus.rnd), 32'd0);
    chk("t6_vld", 32'(bus.rnd_vld), 32'd0);
    chk("t6_lockup", 32'(bus.lockup), 32'd0);
    model_reset();
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    until_grant(4'b1111, "t6b");
    cyc('0, 1'b0, 16'h0);

    rand_run(200, 1'b1);
    cyc('0, 1'b0, 16'h0);
    cyc('0, 1'b0, 16'h0);
    chk("grants_drained", 32'(gq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
